dice_roller: RTL and testbench
==============================

# dice_roller

Downstream consumer of the free-running random-bit generator. Accepts a button press, samples the generator's `rand_bit` output at a fixed divided rate into a 3-bit value, and rejection-samples it to a uniform die face 1..6. The result is shown as a thermometer code on six LEDs. It sits between the random-bit generator and the board LED pins.

## Interface
- `SAMPLE_DIV`, 16: clock cycles between successive `rand_bit` samples; must be ≥2.
- `DEBOUNCE_CYCLES`, 120000: stable-level cycles required by the debouncer (10 ms at 12 MHz).
- `SHOW_CYCLES`, 12000000: cycles the block stays busy in SHOW after a roll.
- `MAX_RETRY`, 8: rejections allowed before the fallback face is used.
- `CLK` in 1: sole clock; all flops on posedge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `rand_bit` in 1: random bit from the generator, synchronous to `CLK`.
- `btn` in 1: raw push-button, active-high, asynchronous.
- `busy` out 1: high in every state except IDLE.
- `valid` out 1: one-cycle pulse when `face` updates.
- `face` out 3: last rolled face, 1..6; 0 only after reset.
- `leds` out 6: thermometer of `face`; bit i is set when i < `face`.

## Operation
- `btn` always passes through a 2-flop synchronizer.
- The press event is the rising edge of the conditioned button level: debounced or raw synchronized, per Configuration.
- FSM states: IDLE, COLLECT, CHECK, SHOW.
- IDLE:
  - On a press event, go to COLLECT.
  - On entry to COLLECT: clear `shreg[2:0]`, `bitcnt`, the divider and `retry`.
- COLLECT:
  - The divider counts 0..SAMPLE_DIV-1.
  - At terminal count: `shreg <= {shreg[1:0], rand_bit}` and `bitcnt` increments.
  - On the third sample, go to CHECK.
- CHECK (one cycle):
  - If `shreg` is in 1..6: `face <= shreg`, pulse `valid`, go to SHOW.
  - Else if `retry == MAX_RETRY-1`: `face <= 1`, pulse `valid`, go to SHOW.
  - Else: increment `retry`, clear `shreg`/`bitcnt`/divider, return to COLLECT.
- SHOW:
  - The hold counter runs to SHOW_CYCLES-1, then the FSM goes to IDLE.
- Press events outside IDLE are dropped, not queued.
- `leds` is combinational from the registered `face`; it holds the last face through IDLE until the next roll.
- Width rules:
  - Divider: $clog2(SAMPLE_DIV) bits.
  - Hold counter: $clog2(SHOW_CYCLES) bits.
  - `retry`: $clog2(MAX_RETRY)+1 bits.
  - No counter wraps; each is cleared on state exit.
- Reset (asserted at any time, including mid-COLLECT or mid-SHOW):
  - State IDLE; `face`=0, `leds`=0, `valid`=0, `busy`=0.
  - All counters, `shreg`, synchronizer and debouncer state cleared.
  - Outputs change immediately on assertion, without waiting for a clock edge.
- A press event and reset deassertion in the same cycle: the press is ignored (synchronizer is cleared).

## Timing
- `busy` rises one cycle after the press event.
- First sample: SAMPLE_DIV cycles after entering COLLECT; subsequent samples every SAMPLE_DIV cycles.
- No-rejection latency from press event to `valid`: 3·SAMPLE_DIV + 2 cycles.
- Each rejection adds 3·SAMPLE_DIV + 1 cycles.
- `valid` and the `face` update occur on the same edge (CHECK→SHOW).
- `busy` falls SHOW_CYCLES cycles after `valid`.
- Added input latency ahead of the press event:
  - Raw path: 3 cycles (2 synchronizer + 1 edge detect).
  - Debounced path: DEBOUNCE_CYCLES more.

## Configuration
- `DICE_DEBOUNCE_EN` defined:
  - The synchronized button feeds the debouncer sub-module.
  - The debounced level changes only after the input is stable for DEBOUNCE_CYCLES consecutive cycles.
- Undefined:
  - The debouncer is not instantiated.
  - The press event is the raw rising edge of the synchronized button.
  - DEBOUNCE_CYCLES is ignored.

## Structure
- Package `dice_pkg`:
  - FSM state enum `dice_state_t` (IDLE=0, COLLECT=1, CHECK=2, SHOW=3).
  - Constants `FACE_MIN=1`, `FACE_MAX=6`, `FACE_FALLBACK=1`.
- Sub-module `btn_debounce`:
  - Ports: CLK, RST_N, in, out.
  - Parameter DEBOUNCE_CYCLES.
  - Resets `out` to 0.

## Test plan
Bench parameters: SAMPLE_DIV=4, SHOW_CYCLES=20, DEBOUNCE_CYCLES=8, MAX_RETRY=8.
- Clean press, `rand_bit` 1,0,1 at sample points -> `valid` pulse 14 cycles after press event; `face`=5, `leds`=6'b011111; `busy` low 20 cycles later.
- `rand_bit` 1,1,1 then 0,1,0 -> one rejection; `face`=2, `leds`=6'b000011, `valid` 27 cycles after press event.
- `rand_bit` held 0 -> 8 rejections, then `face`=1, `leds`=6'b000001, single `valid` pulse.
- Second press during SHOW -> no state change, no extra `valid`; press after `busy` low -> new roll.
- `RST_N` low for 1 cycle mid-COLLECT -> `face`/`leds`/`busy`/`valid` 0 immediately; FSM idle until a new press.
- With `DICE_DEBOUNCE_EN`: 5-cycle `btn` glitch -> no roll; 12-cycle press -> roll. Without it: the 5-cycle glitch starts a roll.

Source files
------------

// File: rtl/dice_pkg.sv
// -----------------------------------------------------------------------------
// dice_pkg
// Shared types and constants for the dice roller.
//   dice_state_t  : roller FSM state encoding
//   FACE_*        : legal face range and the face used when retries run out
//   face_ok       : true when a 3-bit sample is a legal die face
//   face_to_therm : face -> 6-bit thermometer (bit i set when i < face)
// -----------------------------------------------------------------------------
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    SHOW    = 2'd3
  } dice_state_t;

  localparam logic [2:0] FACE_MIN      = 3'd1;
  localparam logic [2:0] FACE_MAX      = 3'd6;
  localparam logic [2:0] FACE_FALLBACK = 3'd1;

  function automatic logic face_ok(input logic [2:0] v);
    return (v >= FACE_MIN) && (v <= FACE_MAX);
  endfunction

  function automatic logic [5:0] face_to_therm(input logic [2:0] f);
    logic [5:0] t;
    for (int i = 0; i < 6; i++) begin
      t[i] = (3'(i) < f);
    end
    return t;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Level debouncer: the output follows the input only after the input has
// differed from the output for DEBOUNCE_CYCLES consecutive clocks.
//   CLK   : clock, posedge
//   RST_N : asynchronous active-low reset (out -> 0)
//   in    : already-synchronized level
//   out   : debounced level
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic in,
  output logic out
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Down-counter reloads whenever input agrees with output, so any bounce
  // back to the current level restarts the stability window.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out <= 1'b0;
      cnt <= CNT_LOAD;
    end else if (in == out) begin
      cnt <= CNT_LOAD;
    end else if (cnt == '0) begin
      out <= in;
      cnt <= CNT_LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/dice_roller.sv
// -----------------------------------------------------------------------------
// dice_roller
// Rolls a uniform die face 1..6 on a button press by collecting three
// rand_bit samples at a divided rate and rejection-sampling the result.
// After MAX_RETRY rejected draws the fallback face is used.
//
// Build option: define DICE_DEBOUNCE_EN to debounce the synchronized button
// (btn_debounce); otherwise the raw synchronized level is edge-detected.
//
// Ports
//   CLK      : sole clock, posedge
//   RST_N    : asynchronous active-low reset
//   rand_bit : random bit, synchronous to CLK
//   btn      : raw push-button, active-high, asynchronous
//   busy     : high whenever the FSM is not idle
//   valid    : one-cycle pulse when face updates
//   face     : last rolled face (0 only after reset)
//   leds     : thermometer of face
//
// state   | meaning
// IDLE    | waiting for a press event
// COLLECT | sampling rand_bit every SAMPLE_DIV cycles, three samples
// CHECK   | accept, reject-and-retry, or fall back
// SHOW    | holding busy for SHOW_CYCLES after a roll
// -----------------------------------------------------------------------------
module dice_roller
  import dice_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned SHOW_CYCLES     = 12000000,
  parameter int unsigned MAX_RETRY       = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       rand_bit,
  input  logic       btn,
  output logic       busy,
  output logic       valid,
  output logic [2:0] face,
  output logic [5:0] leds
);

  localparam int DIV_W   = $clog2(SAMPLE_DIV);
  localparam int HOLD_W  = $clog2(SHOW_CYCLES);
  localparam int RETRY_W = $clog2(MAX_RETRY) + 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(SHOW_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  // ---------------------------------------------------------------------------
  // Button conditioning and press detection
  // ---------------------------------------------------------------------------
  logic btn_s1;
  logic btn_s2;
  logic btn_lvl;
  logic btn_lvl_d;
  logic press_ev;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

`ifdef DICE_DEBOUNCE_EN
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK  (CLK),
    .RST_N(RST_N),
    .in   (btn_s2),
    .out  (btn_lvl)
  );
`else
  assign btn_lvl = btn_s2;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_lvl_d <= 1'b0;
    end else begin
      btn_lvl_d <= btn_lvl;
    end
  end

  assign press_ev = btn_lvl & ~btn_lvl_d;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  dice_state_t state;
  dice_state_t state_nxt;

  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         bit_cnt;
  logic [2:0]         shreg;
  logic [RETRY_W-1:0] retry;
  logic [HOLD_W-1:0]  hold_cnt;

  logic div_tc;
  logic clr_collect;
  logic clr_retry;
  logic do_sample;
  logic take_face;
  logic take_fallback;
  logic inc_retry;

  assign div_tc = (div_cnt == DIV_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    clr_collect   = 1'b0;
    clr_retry     = 1'b0;
    do_sample     = 1'b0;
    take_face     = 1'b0;
    take_fallback = 1'b0;
    inc_retry     = 1'b0;
    unique case (state)
      IDLE: begin
        if (press_ev) begin
          state_nxt   = COLLECT;
          clr_collect = 1'b1;
          clr_retry   = 1'b1;
        end
      end
      COLLECT: begin
        if (div_tc) begin
          do_sample = 1'b1;
          if (bit_cnt == 2'd2) begin
            state_nxt = CHECK;
          end
        end
      end
      CHECK: begin
        if (face_ok(shreg)) begin
          take_face = 1'b1;
          clr_retry = 1'b1;
          state_nxt = SHOW;
        end else if (retry == RETRY_LAST) begin
          take_fallback = 1'b1;
          clr_retry     = 1'b1;
          state_nxt     = SHOW;
        end else begin
          inc_retry   = 1'b1;
          clr_collect = 1'b1;
          state_nxt   = COLLECT;
        end
      end
      SHOW: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Divider only runs in COLLECT and restarts at each terminal count, so it
  // is already zero whenever COLLECT is (re)entered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
    end else if (state == COLLECT && !div_tc) begin
      div_cnt <= div_cnt + 1'b1;
    end else begin
      div_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bit_cnt <= 2'd0;
      shreg   <= 3'd0;
    end else if (clr_collect) begin
      bit_cnt <= 2'd0;
      shreg   <= 3'd0;
    end else if (do_sample) begin
      shreg   <= {shreg[1:0], rand_bit};
      bit_cnt <= (bit_cnt == 2'd2) ? 2'd0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      retry <= '0;
    end else if (clr_retry) begin
      retry <= '0;
    end else if (inc_retry) begin
      retry <= retry + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_cnt <= '0;
    end else if (state == SHOW && hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      face  <= 3'd0;
      valid <= 1'b0;
    end else begin
      valid <= take_face | take_fallback;
      if (take_face) begin
        face <= shreg;
      end else if (take_fallback) begin
        face <= FACE_FALLBACK;
      end
    end
  end

  assign busy = (state != IDLE);
  assign leds = face_to_therm(face);

endmodule

// File: tb/tb_dice_roller.sv
`timescale 1ns/1ps
module tb_dice_roller;

  localparam int SD = 4;
  localparam int SC = 20;
  localparam int DB = 8;
  localparam int MR = 8;
`ifdef DICE_DEBOUNCE_EN
  localparam int OFF = 3 + DB;
`else
  localparam int OFF = 3;
`endif
  localparam int ROUND = 3 * SD + 1;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       rand_bit = 1'b0;
  logic       btn = 1'b0;
  logic       busy;
  logic       valid;
  logic [2:0] face;
  logic [5:0] leds;

  dice_roller #(
    .SAMPLE_DIV     (SD),
    .DEBOUNCE_CYCLES(DB),
    .SHOW_CYCLES    (SC),
    .MAX_RETRY      (MR)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .rand_bit(rand_bit),
    .btn     (btn),
    .busy    (busy),
    .valid   (valid),
    .face    (face),
    .leds    (leds)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic sq [0:63];
  int   base = 0;
  bit   drv_on = 1'b0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // rand_bit schedule: bit j of draw r is presented for the sample edge at
  // OFF + r*ROUND + (j+1)*SD cycles after the button was driven.
  always @(posedge CLK) begin : drv
    int rel, r, p, j;
    #1;
    if (drv_on) begin
      rel = cyc - base + 1 - OFF;
      if (rel > 0) begin
        r = (rel - 1) / ROUND;
        p = rel - ROUND * r;
        j = (p - 1) / SD;
        if (j < 3 && (r * 3 + j) < 64) rand_bit = sq[r*3+j];
      end else begin
        rand_bit = 1'b0;
      end
    end
  end

  task automatic load_seq(input logic [5:0] b);
    for (int i = 0; i < 64; i++) sq[i] = 1'b0;
    for (int i = 0; i < 6; i++) sq[i] = b[5-i];
  endtask

  task automatic idle_chk(input string tag, input int ncyc);
    int seen = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge CLK); #1;
      if (busy || valid) seen++;
    end
    chk_val(tag, seen, 0);
  endtask

  task automatic do_roll(input string tag, input logic [5:0] bits, input int btn_len,
                         input int exp_rej, input logic [2:0] exp_face,
                         input logic [5:0] exp_leds, input bit repress);
    int busy_n = -1;
    int valid_n = -1;
    int fall_n = -1;
    int pulses = 0;
    logic [2:0] f_at = 3'd0;
    logic [5:0] l_at = 6'd0;
    load_seq(bits);
    @(posedge CLK); #1;
    btn = 1'b1;
    base = cyc;
    drv_on = 1'b1;
    for (int k = 1; k <= 400 && fall_n < 0; k++) begin
      @(posedge CLK); #1;
      if (k == btn_len) btn = 1'b0;
      if (busy && busy_n < 0) busy_n = k;
      if (valid) begin
        pulses++;
        if (valid_n < 0) begin
          valid_n = k;
          f_at = face;
          l_at = leds;
        end
      end
      if (repress && valid_n >= 0) begin
        if (k == valid_n + 3) btn = 1'b1;
        if (k == valid_n + 15) btn = 1'b0;
      end
      if (!busy && busy_n >= 0) fall_n = k;
    end
    drv_on = 1'b0;
    btn = 1'b0;
    chk_val({tag, "_busy_rise"}, busy_n, OFF);
    chk_val({tag, "_valid_lat"}, valid_n, OFF + ROUND * (exp_rej + 1));
    chk_val({tag, "_face"}, f_at, exp_face);
    chk_val({tag, "_leds"}, l_at, exp_leds);
    chk_val({tag, "_pulses"}, pulses, 1);
    chk_val({tag, "_busy_fall"}, fall_n - valid_n, SC);
  endtask

  initial begin
    #12;
    chk_val("rst_face", face, 0);
    chk_val("rst_leds", leds, 0);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_valid", valid, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);

    do_roll("f5", 6'b101000, 12, 0, 3'd5, 6'b011111, 1'b0);
    idle_chk("gap_f5", 30);
    do_roll("rej1", 6'b111010, 12, 1, 3'd2, 6'b000011, 1'b0);
    idle_chk("gap_rej1", 30);
    do_roll("fallback", 6'b000000, 12, MR - 1, 3'd1, 6'b000001, 1'b0);
    idle_chk("gap_fb", 30);
    do_roll("repress", 6'b110000, 12, 0, 3'd6, 6'b111111, 1'b1);
    idle_chk("repress_dropped", 40);

    // reset in the middle of COLLECT
    load_seq(6'b101000);
    @(posedge CLK); #1;
    btn = 1'b1;
    base = cyc;
    drv_on = 1'b1;
    repeat (OFF + 1) @(posedge CLK);
    #1 btn = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk_val("mid_busy", busy, 1);
    #2 RST_N = 1'b0;
    #1;
    chk_val("async_face", face, 0);
    chk_val("async_leds", leds, 0);
    chk_val("async_busy", busy, 0);
    chk_val("async_valid", valid, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    drv_on = 1'b0;
    idle_chk("rst_stays_idle", 40);
    do_roll("post_rst", 6'b110000, 12, 0, 3'd6, 6'b111111, 1'b0);
    idle_chk("gap_post_rst", 30);

`ifdef DICE_DEBOUNCE_EN
    @(posedge CLK); #1;
    btn = 1'b1;
    repeat (5) @(posedge CLK);
    #1 btn = 1'b0;
    idle_chk("glitch_ignored", 40);
`else
    do_roll("glitch", 6'b011000, 5, 0, 3'd3, 6'b000111, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
